seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 26 ++
 rtl/seg_scan_ctrl_decode.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 176 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the eight-digit seven-segment scan controller.
package seg_scan_ctrl_pkg;

    // Scan FSM: dead time with all anodes off, then the lit portion of the slot.
    typedef enum logic [0:0] {
        GUARD = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 8;

    // Active-low segment patterns (a..g on bits 6..0).
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // All anodes off (active-low).
    localparam logic [7:0] AN_OFF = 8'hFF;

    // One-cold anode pattern: only bit idx driven low.
    function automatic logic [7:0] anode_select(input logic [2:0] idx);
        logic [7:0] one_hot;
        one_hot = 8'b0000_0001 << idx;
        return ~one_hot;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// BCD nibble to active-low seven-segment pattern; non-decimal codes show a dash.
module seg_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pure lookup from nibble to segment pattern (a..g on bits 6..0).
    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed eight-digit seven-segment scan controller with a double-buffered
// frame write port. Frames swap in only at the end of digit 7 so the viewer
// never sees a half-updated display; while disabled, swaps happen immediately.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_bcd,
    input  logic [7:0]  wr_blank,
    input  logic [7:0]  wr_dp,
    output logic [7:0]  an,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST       = 3'(NUM_DIGITS - 1);

    // Scan state
    scan_state_t      state_r;
    logic [2:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;

    // Registered display outputs
    logic [7:0]       an_r;
    logic [6:0]       cathode_r;
    logic             dp_r;
    logic             frame_done_r;

    // Frame buffers: active drives the display, pending holds the next frame.
    logic [31:0]      act_bcd_r;
    logic [7:0]       act_blank_r;
    logic [7:0]       act_dp_r;
    logic [31:0]      pend_bcd_r;
    logic [7:0]       pend_blank_r;
    logic [7:0]       pend_dp_r;
    logic             wr_ready_r;   // 1 = pending buffer empty

    // Decode and control strobes
    logic [3:0]       nibble_s;
    logic [6:0]       seg_s;
    logic             guard_end_s;
    logic             slot_end_s;
    logic             boundary_s;
    logic             accept_s;
    logic             load_active_s;

    // Pick the nibble of the digit currently being scanned.
    always_comb begin
        nibble_s = act_bcd_r[{idx_r, 2'b00} +: 4];
    end

    seg_decode u_seg_decode (
        .bcd (nibble_s),
        .seg (seg_s)
    );

    // Slot timing strobes and buffer-transfer conditions.
    always_comb begin
        guard_end_s   = (state_r == GUARD) && (cnt_r == CNT_GUARD_LAST);
        slot_end_s    = (state_r == SHOW) && (cnt_r == CNT_LAST);
        boundary_s    = en && slot_end_s && (idx_r == IDX_LAST);
        accept_s      = wr_valid && wr_ready_r;
        // A full pending buffer drains at a frame boundary, or at once while dark.
        load_active_s = !wr_ready_r && (boundary_s || !en);
    end

    // Write handshake and double-buffered frame storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_bcd_r    <= 32'h0000_0000;
            act_blank_r  <= 8'hFF;
            act_dp_r     <= 8'h00;
            pend_bcd_r   <= 32'h0000_0000;
            pend_blank_r <= 8'h00;
            pend_dp_r    <= 8'h00;
            wr_ready_r   <= 1'b1;
        end else begin
            if (load_active_s) begin
                act_bcd_r   <= pend_bcd_r;
                act_blank_r <= pend_blank_r;
                act_dp_r    <= pend_dp_r;
                wr_ready_r  <= 1'b1;
            end else if (accept_s) begin
                pend_bcd_r   <= wr_bcd;
                pend_blank_r <= wr_blank;
                pend_dp_r    <= wr_dp;
                wr_ready_r   <= 1'b0;
            end else begin
                wr_ready_r <= wr_ready_r;
            end
        end
    end

    // Scan FSM with outputs updated on the same edge as each state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= GUARD;
            idx_r        <= 3'd0;
            cnt_r        <= '0;
            an_r         <= AN_OFF;
            cathode_r    <= SEG_BLANK;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else if (!en) begin
            // Parked at the start of digit 0 so re-enable gets a full guard.
            state_r      <= GUARD;
            idx_r        <= 3'd0;
            cnt_r        <= '0;
            an_r         <= AN_OFF;
            cathode_r    <= SEG_BLANK;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= boundary_s;
            case (state_r)
                GUARD: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (guard_end_s) begin
                        state_r <= SHOW;
                        if (act_blank_r[idx_r]) begin
                            // Blanked digit: keep every driver off for the whole slot.
                            an_r      <= AN_OFF;
                            cathode_r <= SEG_BLANK;
                            dp_r      <= 1'b1;
                        end else begin
                            an_r      <= anode_select(idx_r);
                            cathode_r <= seg_s;
                            dp_r      <= ~act_dp_r[idx_r];
                        end
                    end else begin
                        state_r <= GUARD;
                    end
                end
                SHOW: begin
                    if (slot_end_s) begin
                        state_r   <= GUARD;
                        cnt_r     <= '0;
                        idx_r     <= idx_r + 3'd1;
                        an_r      <= AN_OFF;
                        cathode_r <= SEG_BLANK;
                        dp_r      <= 1'b1;
                    end else begin
                        state_r <= SHOW;
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r   <= GUARD;
                    idx_r     <= 3'd0;
                    cnt_r     <= '0;
                    an_r      <= AN_OFF;
                    cathode_r <= SEG_BLANK;
                    dp_r      <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready   = wr_ready_r;
    assign an         = an_r;
    assign cathode    = cathode_r;
    assign dp         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with an 8-cycle slot and 2-cycle guard.
// Slot timing after a boundary edge B: edge B+8d+k shows digit d, dark for
// k = 0,1 and lit for k = 2..7.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_bcd;
    logic [7:0]  wr_blank;
    logic [7:0]  wr_dp;
    logic [7:0]  an;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_done;

    int vec_cnt = 0;
    int err_cnt = 0;

    seg_scan_ctrl #(
        .REFRESH_DIV  (8),
        .GUARD_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_bcd     (wr_bcd),
        .wr_blank   (wr_blank),
        .wr_dp      (wr_dp),
        .an         (an),
        .cathode    (cathode),
        .dp         (dp),
        .frame_done (frame_done)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until frame_done is seen, giving up after 80 edges.
    task automatic wait_boundary(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            step();
            if (frame_done === 1'b1) seen = 1'b1;
        end
    endtask

    // Offer one frame for exactly one edge.
    task automatic write_frame(input logic [31:0] b, input logic [7:0] bl, input logic [7:0] d);
        wr_bcd   = b;
        wr_blank = bl;
        wr_dp    = d;
        wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0;
        wr_bcd = 32'h0; wr_blank = 8'h0; wr_dp = 8'h0;
        step_n(3);
        vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL reset_an: got %h want ff", an); end
        vec_cnt++; if (cathode !== 7'h7F) begin err_cnt++; $display("FAIL reset_cathode: got %h want 7f", cathode); end
        vec_cnt++; if (dp !== 1'b1) begin err_cnt++; $display("FAIL reset_dp: got %b want 1", dp); end
        vec_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_idle_frame();
        logic exp_fd;
        en = 1'b1;
        rst_n = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            step();
            exp_fd = (n == 64);
            vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL idle_an cyc %0d: got %h want ff", n, an); end
            vec_cnt++; if (frame_done !== exp_fd) begin err_cnt++; $display("FAIL idle_frame_done cyc %0d: got %b want %b", n, frame_done, exp_fd); end
        end
    endtask

    task automatic test_display();
        bit seen;
        write_frame(32'h7654_3210, 8'h00, 8'h01);
        vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL disp_accept: got %b want 0", wr_ready); end
        wait_boundary(seen);
        vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL disp_boundary: got none want pulse"); end
        vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL disp_ready_back: got %b want 1", wr_ready); end
        vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL disp_guard0: got %h want ff", an); end
        step();
        vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL disp_guard1: got %h want ff", an); end
        step();
        vec_cnt++; if (an !== 8'hFE) begin err_cnt++; $display("FAIL disp_d0_an: got %h want fe", an); end
        vec_cnt++; if (cathode !== 7'b0000001) begin err_cnt++; $display("FAIL disp_d0_cathode: got %b want 0000001", cathode); end
        vec_cnt++; if (dp !== 1'b0) begin err_cnt++; $display("FAIL disp_d0_dp: got %b want 0", dp); end
        step_n(5);
        vec_cnt++; if (an !== 8'hFE) begin err_cnt++; $display("FAIL disp_d0_last: got %h want fe", an); end
        step();
        vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL disp_d1_guard: got %h want ff", an); end
        step_n(2);
        vec_cnt++; if (an !== 8'hFD) begin err_cnt++; $display("FAIL disp_d1_an: got %h want fd", an); end
        vec_cnt++; if (cathode !== 7'b1001111) begin err_cnt++; $display("FAIL disp_d1_cathode: got %b want 1001111", cathode); end
        vec_cnt++; if (dp !== 1'b1) begin err_cnt++; $display("FAIL disp_d1_dp: got %b want 1", dp); end
        step_n(16);
        vec_cnt++; if (an !== 8'hF7) begin err_cnt++; $display("FAIL disp_d3_an: got %h want f7", an); end
        vec_cnt++; if (cathode !== 7'b0000110) begin err_cnt++; $display("FAIL disp_d3_cathode: got %b want 0000110", cathode); end
    endtask

    task automatic test_backpressure();
        bit seen;
        write_frame(32'h1111_1111, 8'h00, 8'h00);
        vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_first_accept: got %b want 0", wr_ready); end
        wr_bcd = 32'h2222_2222; wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_held_ready: got %b want 0", wr_ready); end
        end
        wr_valid = 1'b0;
        wait_boundary(seen);
        vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL bp_boundary: got none want pulse"); end
        vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_ready_back: got %b want 1", wr_ready); end
        step_n(2);
        vec_cnt++; if (cathode !== 7'b1001111) begin err_cnt++; $display("FAIL bp_first_shown: got %b want 1001111", cathode); end
        write_frame(32'h3333_3333, 8'h00, 8'h00);
        vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_third_accept: got %b want 0", wr_ready); end
        vec_cnt++; if (cathode !== 7'b1001111) begin err_cnt++; $display("FAIL bp_no_midframe_swap: got %b want 1001111", cathode); end
        step_n(55);
        vec_cnt++; if (an !== 8'h7F) begin err_cnt++; $display("FAIL bp_d7_an: got %h want 7f", an); end
        vec_cnt++; if (cathode !== 7'b1001111) begin err_cnt++; $display("FAIL bp_d7_cathode: got %b want 1001111", cathode); end
        wait_boundary(seen);
        vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL bp_boundary2: got none want pulse"); end
        step_n(2);
        vec_cnt++; if (cathode !== 7'b0000110) begin err_cnt++; $display("FAIL bp_third_shown: got %b want 0000110", cathode); end
        vec_cnt++; if (an !== 8'hFE) begin err_cnt++; $display("FAIL bp_third_an: got %h want fe", an); end
    endtask

    task automatic test_dash_blank();
        bit seen;
        write_frame(32'h00C0_0000, 8'h00, 8'h00);
        wait_boundary(seen);
        vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL dash_boundary: got none want pulse"); end
        step_n(42);
        vec_cnt++; if (an !== 8'hDF) begin err_cnt++; $display("FAIL dash_d5_an: got %h want df", an); end
        vec_cnt++; if (cathode !== 7'b1111110) begin err_cnt++; $display("FAIL dash_d5_cathode: got %b want 1111110", cathode); end
        step_n(5);
        vec_cnt++; if (cathode !== 7'b1111110) begin err_cnt++; $display("FAIL dash_d5_last: got %b want 1111110", cathode); end
        write_frame(32'h00C0_0000, 8'h20, 8'h00);
        wait_boundary(seen);
        vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL blank_boundary: got none want pulse"); end
        step_n(34);
        vec_cnt++; if (an !== 8'hEF) begin err_cnt++; $display("FAIL blank_d4_an: got %h want ef", an); end
        vec_cnt++; if (cathode !== 7'b0000001) begin err_cnt++; $display("FAIL blank_d4_cathode: got %b want 0000001", cathode); end
        step_n(6);
        for (int k = 0; k < 8; k++) begin
            vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL blank_d5_an k%0d: got %h want ff", k, an); end
            step();
        end
    endtask

    task automatic test_enable();
        bit seen;
        wait_boundary(seen);
        vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL en_boundary: got none want pulse"); end
        step_n(34);
        vec_cnt++; if (an !== 8'hEF) begin err_cnt++; $display("FAIL en_d4_lit: got %h want ef", an); end
        en = 1'b0;
        step();
        vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL en_off_an: got %h want ff", an); end
        vec_cnt++; if (cathode !== 7'h7F) begin err_cnt++; $display("FAIL en_off_cathode: got %h want 7f", cathode); end
        write_frame(32'h8765_4321, 8'h00, 8'h00);
        vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL en_off_accept: got %b want 0", wr_ready); end
        step();
        vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL en_off_drain: got %b want 1", wr_ready); end
        for (int i = 0; i < 40; i++) begin
            step();
            vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL en_off_dark: got %h want ff", an); end
            vec_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL en_off_frame_done: got %b want 0", frame_done); end
        end
        en = 1'b1;
        step();
        vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL en_on_guard: got %h want ff", an); end
        step();
        vec_cnt++; if (an !== 8'hFE) begin err_cnt++; $display("FAIL en_on_lit_an: got %h want fe", an); end
        vec_cnt++; if (cathode !== 7'b1001111) begin err_cnt++; $display("FAIL en_on_lit_cathode: got %b want 1001111", cathode); end
        vec_cnt++; if (dp !== 1'b1) begin err_cnt++; $display("FAIL en_on_lit_dp: got %b want 1", dp); end
    endtask

    task automatic test_async_reset();
        logic exp_fd;
        write_frame(32'h9999_9999, 8'h00, 8'hFF);
        vec_cnt++; if (wr_ready !== 1'b0) begin err_cnt++; $display("FAIL ares_accept: got %b want 0", wr_ready); end
        vec_cnt++; if (an !== 8'hFE) begin err_cnt++; $display("FAIL ares_pre_lit: got %h want fe", an); end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL ares_an: got %h want ff", an); end
        vec_cnt++; if (cathode !== 7'h7F) begin err_cnt++; $display("FAIL ares_cathode: got %h want 7f", cathode); end
        vec_cnt++; if (dp !== 1'b1) begin err_cnt++; $display("FAIL ares_dp: got %b want 1", dp); end
        vec_cnt++; if (wr_ready !== 1'b1) begin err_cnt++; $display("FAIL ares_wr_ready: got %b want 1", wr_ready); end
        vec_cnt++; if (frame_done !== 1'b0) begin err_cnt++; $display("FAIL ares_frame_done: got %b want 0", frame_done); end
        step_n(2);
        rst_n = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            step();
            exp_fd = (n == 64);
            vec_cnt++; if (an !== 8'hFF) begin err_cnt++; $display("FAIL ares_dark cyc %0d: got %h want ff", n, an); end
            vec_cnt++; if (frame_done !== exp_fd) begin err_cnt++; $display("FAIL ares_frame_done cyc %0d: got %b want %b", n, frame_done, exp_fd); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_display();
        test_backpressure();
        test_dash_blank();
        test_enable();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
